// File: rtl/spi_shift_engine.sv
// -----------------------------------------------------------------------------
// spi_shift_engine
//
// Frames one WIDTH-bit serial transfer for the SPI path. A load captures the
// word to transmit and the bit order for this transfer. Each peripheral clock
// edge strobe then shifts one bit out and one bit in. A bit counter reports
// progress, so the controlling FSM above does not have to count edges.
//
// Strobe semantics: peripheralClkEdge and load are single-cycle qualifiers
// sampled on the rising edge of clk. There is no back-pressure. A strobe that
// arrives in a state that does not use it is dropped. It is not held for later.
//
// Optional feature (macro SHIFT_PARITY_EN):
//   When defined, adds parityOut. It is the XOR of the received word, captured
//   on the DONE cycle. It holds until the next DONE cycle.
//
// Parameters:
//   WIDTH  shift register / data bus width in bits (>= 2)
//   CNT_W  width of bitCount
//
// Ports:
//   clk                in   system clock, rising edge
//   resetN             in   asynchronous active-low reset
//   peripheralClkEdge  in   one-clk strobe: shift one bit this cycle
//   load               in   start a transfer (accepted in IDLE or DONE)
//   lsbFirst           in   bit order for the transfer, sampled on load
//   parallelDataIn     in   word to transmit
//   serialDataIn       in   incoming serial bit
//   parallelDataOut    out  shift register contents
//   serialDataOut      out  outgoing bit (combinational from register + order)
//   busy               out  transfer in progress
//   done               out  one-clk pulse after the final bit has shifted
//   bitCount           out  bits shifted in the current transfer
//   parityOut          out  (SHIFT_PARITY_EN only) parity of the last received word
// -----------------------------------------------------------------------------
module spi_shift_engine #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             peripheralClkEdge,
    input  logic             load,
    input  logic             lsbFirst,
    input  logic [WIDTH-1:0] parallelDataIn,
    input  logic             serialDataIn,
    output logic [WIDTH-1:0] parallelDataOut,
    output logic             serialDataOut,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bitCount
`ifdef SHIFT_PARITY_EN
    ,
    output logic             parityOut
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } stateType;

    // Count value held after the edge that completes the word.
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(WIDTH);
    // Count value present when the final edge of the word arrives.
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

    stateType          state;
    stateType          stateNext;
    logic [WIDTH-1:0]  shiftReg;
    logic [WIDTH-1:0]  shiftRegNext;
    logic              lsbDir;
    logic              lsbDirNext;
    logic [CNT_W-1:0]  countNext;
    logic              busyNext;
    logic              doneNext;

    // ------------------------------------------------------------------
    // Next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        stateNext    = state;
        shiftRegNext = shiftReg;
        lsbDirNext   = lsbDir;
        countNext    = bitCount;

        case (state)
            IDLE, DONE: begin
                // A load in DONE starts the next transfer directly, so
                // back-to-back words need no idle gap. A simultaneous edge
                // strobe is dropped. It belongs to no transfer yet.
                if (load) begin
                    shiftRegNext = parallelDataIn;
                    lsbDirNext   = lsbFirst;
                    countNext    = '0;
                    stateNext    = SHIFT;
                end else if (state == DONE) begin
                    stateNext = IDLE;
                end
            end

            SHIFT: begin
                // load is ignored here. Only reset aborts a transfer.
                if (peripheralClkEdge) begin
                    if (lsbDir) begin
                        shiftRegNext = {serialDataIn, shiftReg[WIDTH-1:1]};
                    end else begin
                        shiftRegNext = {shiftReg[WIDTH-2:0], serialDataIn};
                    end
                    // Saturating increment, so bitCount can never wrap.
                    if (bitCount != FULL_COUNT) begin
                        countNext = bitCount + CNT_W'(1);
                    end
                    if (bitCount == LAST_COUNT) begin
                        stateNext = DONE;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        // Status flags are registered copies of the upcoming state.
        // They line up with the state register and add no decode delay.
        busyNext = (stateNext == SHIFT);
        doneNext = (stateNext == DONE);
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            shiftReg <= '0;
            lsbDir   <= 1'b0;
            bitCount <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= stateNext;
            shiftReg <= shiftRegNext;
            lsbDir   <= lsbDirNext;
            bitCount <= countNext;
            busy     <= busyNext;
            done     <= doneNext;
        end
    end

    assign parallelDataOut = shiftReg;

    // The outgoing bit is the end of the register that leaves next.
    // It follows the register combinationally, so it presents the next bit
    // in the cycle after each shift.
    assign serialDataOut = lsbDir ? shiftReg[0] : shiftReg[WIDTH-1];

`ifdef SHIFT_PARITY_EN
    // In DONE the register holds the completed received word.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            parityOut <= 1'b0;
        end else if (state == DONE) begin
            parityOut <= ^shiftReg;
        end
    end
`endif

endmodule

// File: tb/tb_spi_shift_engine.sv
// -----------------------------------------------------------------------------
// tb_spi_shift_engine
//
// Bench for spi_shift_engine with WIDTH=8.
// Contents:
//   - a cycle table for one MSB-first transfer, including a simultaneous
//     load+edge, an ignored mid-transfer load, and edges ignored in IDLE/DONE;
//   - scoreboarded transfers with LSB-first, back-to-back and random words;
//   - an asynchronous reset in the middle of a transfer.
// Inputs are driven 1 ns after the rising edge. Outputs are sampled at the
// same point, after the DUT has settled.
// -----------------------------------------------------------------------------
module tb_spi_shift_engine;

    localparam int W = 8;

    logic         clk;
    logic         resetN;
    logic         peripheralClkEdge;
    logic         load;
    logic         lsbFirst;
    logic [W-1:0] parallelDataIn;
    logic         serialDataIn;
    logic [W-1:0] parallelDataOut;
    logic         serialDataOut;
    logic         busy;
    logic         done;
    logic [3:0]   bitCount;
`ifdef SHIFT_PARITY_EN
    logic         parityOut;
`endif

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_q[$];

    spi_shift_engine #(.WIDTH(W)) dut (
        .clk               (clk),
        .resetN            (resetN),
        .peripheralClkEdge (peripheralClkEdge),
        .load              (load),
        .lsbFirst          (lsbFirst),
        .parallelDataIn    (parallelDataIn),
        .serialDataIn      (serialDataIn),
        .parallelDataOut   (parallelDataOut),
        .serialDataOut     (serialDataOut),
        .busy              (busy),
        .done              (done),
        .bitCount          (bitCount)
`ifdef SHIFT_PARITY_EN
        ,
        .parityOut         (parityOut)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of inputs. It returns 1 ns after the rising edge that
    // consumed them, which is where outputs are sampled.
    task automatic drive(input logic ld, input logic lsb, input logic [W-1:0] din,
                         input logic pe, input logic sin);
        load              = ld;
        lsbFirst          = lsb;
        parallelDataIn    = din;
        peripheralClkEdge = pe;
        serialDataIn      = sin;
        @(posedge clk);
        #1;
        load              = 1'b0;
        peripheralClkEdge = 1'b0;
    endtask

    // Full transfer with the scoreboard. The bit sent before edge k is the
    // k-th bit of the loaded word in transfer order. The received word equals
    // sinWord, because its bits are fed in that same order. This task returns
    // in the DONE cycle.
    task automatic transfer(input logic [W-1:0] data, input logic lsb,
                            input logic [W-1:0] sinWord, input string tag);
        logic [W-1:0] got;
        logic         sbit;
        int           gap;
        drive(1'b1, lsb, data, 1'b0, 1'b0);
        chk({tag, "_load_busy"}, 32'(busy), 32'd1);
        chk({tag, "_load_cnt"},  32'(bitCount), 32'd0);
        chk({tag, "_load_reg"},  32'(parallelDataOut), 32'(data));
        for (int k = 0; k < W; k++) begin
            exp_q.push_back(W'(lsb ? data[k] : data[W-1-k]));
            gap = $urandom_range(0, 1);
            for (int g = 0; g < gap; g++) begin
                // Cycle with no edge: everything holds. A stray load is ignored.
                drive(1'b1, ~lsb, 8'h00, 1'b0, 1'b0);
                chk({tag, "_gap_cnt"},  32'(bitCount), 32'(k));
                chk({tag, "_gap_busy"}, 32'(busy), 32'd1);
            end
            got = exp_q.pop_front();
            chk($sformatf("%s_sdo%0d", tag, k), 32'(serialDataOut), 32'(got));
            sbit = lsb ? sinWord[k] : sinWord[W-1-k];
            drive(1'b0, 1'b0, 8'h00, 1'b1, sbit);
            if (k < W - 1) begin
                chk($sformatf("%s_cnt%0d", tag, k), 32'(bitCount), 32'(k + 1));
                chk($sformatf("%s_done%0d", tag, k), 32'(done), 32'd0);
            end else begin
                chk({tag, "_done"},     32'(done), 32'd1);
                chk({tag, "_end_busy"}, 32'(busy), 32'd0);
                chk({tag, "_end_cnt"},  32'(bitCount), 32'd8);
            end
        end
        exp_q.push_back(sinWord);
        got = exp_q.pop_front();
        chk({tag, "_rx_word"}, 32'(parallelDataOut), 32'(got));
    endtask

    // Called in the DONE cycle. It drives an edge strobe, which must be
    // ignored, and then checks the IDLE state.
    task automatic idle_check(input logic [W-1:0] expWord, input string tag);
        drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk({tag, "_idle_done"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
        chk({tag, "_idle_cnt"},  32'(bitCount), 32'd8);
        chk({tag, "_idle_reg"},  32'(parallelDataOut), 32'(expWord));
`ifdef SHIFT_PARITY_EN
        chk({tag, "_parity"}, 32'(parityOut), 32'(^expWord));
`endif
    endtask

    // ---------------- cycle table ----------------
    typedef struct packed {
        logic         ld;
        logic         lsb;
        logic [W-1:0] din;
        logic         pe;
        logic         sin;
        logic [W-1:0] expReg;
        logic         expBusy;
        logic         expDone;
        logic [3:0]   expCnt;
        logic         expSdo;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic [W-1:0] rnd;
        logic [W-1:0] rin;
        logic         rlsb;

        // ld lsb din pe sin | reg busy done cnt sdo
        vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 4'd0, 1'b0}; // edge in IDLE ignored
        vecs[1]  = '{1'b1, 1'b0, 8'hF0, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b0, 4'd0, 1'b1}; // load wins over edge
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hE1, 1'b1, 1'b0, 4'd1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 8'hE1, 1'b1, 1'b0, 4'd1, 1'b1}; // no edge: hold
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 4'd2, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 8'h87, 1'b1, 1'b0, 4'd3, 1'b1}; // mid-shift load ignored
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 4'd4, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b0, 4'd5, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h3F, 1'b1, 1'b0, 4'd6, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b0, 4'd7, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 4'd8, 1'b1}; // done pulse
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 4'd8, 1'b1}; // edge in DONE ignored

        // ---------------- reset ----------------
        resetN            = 1'b0;
        load              = 1'b0;
        lsbFirst          = 1'b0;
        parallelDataIn    = '0;
        peripheralClkEdge = 1'b0;
        serialDataIn      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;
        chk("rst_reg",  32'(parallelDataOut), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_cnt",  32'(bitCount), 32'd0);
        chk("rst_sdo",  32'(serialDataOut), 32'd0);
`ifdef SHIFT_PARITY_EN
        chk("rst_parity", 32'(parityOut), 32'd0);
`endif

        // ---------------- table: MSB-first F0 with serialDataIn=1 ----------------
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ld, vecs[i].lsb, vecs[i].din, vecs[i].pe, vecs[i].sin);
            chk($sformatf("vec%0d_reg", i),  32'(parallelDataOut), 32'(vecs[i].expReg));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].expDone));
            chk($sformatf("vec%0d_cnt", i),  32'(bitCount), 32'(vecs[i].expCnt));
            chk($sformatf("vec%0d_sdo", i),  32'(serialDataOut), 32'(vecs[i].expSdo));
        end

        // ---------------- LSB-first 01, receiving C3 ----------------
        transfer(8'h01, 1'b1, 8'hC3, "lsb01");
        idle_check(8'hC3, "lsb01");

        // ---------------- parity 1: receive 07 ----------------
        transfer(8'h96, 1'b1, 8'h07, "rx07");
        idle_check(8'h07, "rx07");
`ifdef SHIFT_PARITY_EN
        chk("parity_07", 32'(parityOut), 32'd1);
`endif

        // ---------------- back-to-back: 3C loaded on the DONE cycle ----------------
        transfer(8'h5A, 1'b0, 8'hA5, "b2b_first");
        transfer(8'h3C, 1'b0, 8'h03, "b2b_second");
        idle_check(8'h03, "b2b_second");
`ifdef SHIFT_PARITY_EN
        chk("parity_03", 32'(parityOut), 32'd0);
`endif

        // ---------------- random transfers ----------------
        for (int r = 0; r < 4; r++) begin
            rnd  = W'($urandom_range(0, 255));
            rin  = W'($urandom_range(0, 255));
            rlsb = 1'($urandom_range(0, 1));
            transfer(rnd, rlsb, rin, $sformatf("rnd%0d", r));
            idle_check(rin, $sformatf("rnd%0d", r));
        end

        // ---------------- reset mid-SHIFT ----------------
        drive(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0);
        chk("mid_load_reg", 32'(parallelDataOut), 32'hA5);
        for (int e = 0; e < 3; e++) drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("mid_pre_cnt", 32'(bitCount), 32'd3);
        #2;
        resetN = 1'b0;
        #1;
        chk("mid_rst_reg",  32'(parallelDataOut), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_cnt",  32'(bitCount), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        for (int e = 0; e < 6; e++) begin
            drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
            chk($sformatf("post_rst_done%0d", e), 32'(done), 32'd0);
            chk($sformatf("post_rst_reg%0d", e),  32'(parallelDataOut), 32'd0);
            chk($sformatf("post_rst_cnt%0d", e),  32'(bitCount), 32'd0);
            chk($sformatf("post_rst_busy%0d", e), 32'(busy), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
